// File: rtl/mispredict_arb.sv
// Mispredict arbiter: picks the oldest resolving-unit report by ROB age and
// holds it as a level to recovery_ctrl until recovery completes.
module mispredict_arb #(
  parameter int NUM_REQ      = 2,
  parameter int ROB_W        = 4,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ROB_W-1:0]         rob_head_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*ROB_W-1:0] req_tag_i,
  input  logic [NUM_REQ*32-1:0]    req_target_i,
  input  logic                     recover_done_i,
  output logic                     mispredict_o,
  output logic [31:0]              target_pc_o,
  output logic [ROB_W-1:0]         recover_tag_o,
  output logic                     busy_o,
  output logic                     err_o,
  output logic [15:0]              mp_count_o
);

  localparam int CW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [ROB_W-1:0] tag_q, tag_d;
  logic [31:0]      pc_q, pc_d;
  logic             pend_v_q, pend_v_d;
  logic [ROB_W-1:0] pend_tag_q, pend_tag_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [15:0]      count_q, count_d;

  function automatic logic [ROB_W-1:0] age_of(
    input logic [ROB_W-1:0] t,
    input logic [ROB_W-1:0] h
  );
    return t - h;
  endfunction

  logic             req_v;
  logic [ROB_W-1:0] req_tag;
  logic [31:0]      req_pc;
  logic [ROB_W-1:0] req_age;

  // Oldest valid report this cycle; strict compare keeps lowest index on ties
  always_comb begin
    req_v   = 1'b0;
    req_tag = '0;
    req_pc  = '0;
    req_age = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid_i[k] &&
          (!req_v ||
           age_of(req_tag_i[k*ROB_W +: ROB_W], rob_head_i) < req_age)) begin
        req_v   = 1'b1;
        req_tag = req_tag_i[k*ROB_W +: ROB_W];
        req_pc  = req_target_i[k*32 +: 32];
        req_age = age_of(req_tag_i[k*ROB_W +: ROB_W], rob_head_i);
      end
    end
  end

  logic [ROB_W-1:0] pend_age;
  logic [ROB_W-1:0] held_age;
  logic             pend_wins;
  logic             cand_v;
  logic [ROB_W-1:0] cand_tag;
  logic [31:0]      cand_pc;
  logic             to_pend;
  logic [CW-1:0]    cnt_inc;

  always_comb begin
    pend_age  = age_of(pend_tag_q, rob_head_i);
    held_age  = age_of(tag_q, rob_head_i);
    pend_wins = pend_v_q && (!req_v || pend_age < req_age);
    cand_v    = req_v || pend_v_q;
    cand_tag  = pend_wins ? pend_tag_q : req_tag;
    cand_pc   = pend_wins ? pend_pc_q : req_pc;
    to_pend   = req_v && (req_age < held_age) &&
                (!pend_v_q || !(pend_age < req_age));
    cnt_inc   = cnt_q + CW'(1);
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_tag_d = pend_tag_q;
    pend_pc_d  = pend_pc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    count_d    = count_q;
    unique case (state_q)
      IDLE, GAP: begin
        cnt_d    = '0;
        pend_v_d = 1'b0;
        if (cand_v) begin
          state_d = ACTIVE;
          tag_d   = cand_tag;
          pc_d    = cand_pc;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        cnt_d = cnt_inc;
        if (recover_done_i) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_inc == CW'(DONE_TIMEOUT)) begin
          state_d = GAP;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
        // Older reports survive the flush; the timeout path freezes pending
        if (to_pend && (recover_done_i || cnt_inc != CW'(DONE_TIMEOUT))) begin
          pend_v_d   = 1'b1;
          pend_tag_d = req_tag;
          pend_pc_d  = req_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tag_q      <= '0;
      pc_q       <= '0;
      pend_v_q   <= 1'b0;
      pend_tag_q <= '0;
      pend_pc_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_tag_q <= pend_tag_d;
      pend_pc_q  <= pend_pc_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign mispredict_o  = (state_q == ACTIVE);
  assign busy_o        = (state_q != IDLE);
  assign target_pc_o   = pc_q;
  assign recover_tag_o = tag_q;
  assign err_o         = err_q;
  assign mp_count_o    = count_q;

endmodule
